// File: rtl/display_pkg.sv
// Shared types and constants for the display write queue: frame geometry,
// sequencer states and the buffered write entry.
package display_pkg;

  localparam int unsigned DEFAULT_WIDTH  = 267;
  localparam int unsigned DEFAULT_HEIGHT = 240;

  // Pixel count of one frame, truncated to the 20-bit framebuffer address space.
  function automatic logic [19:0] fb_pixels(input int unsigned w, input int unsigned h);
    return 20'(w * h);
  endfunction

  localparam logic [19:0] FB_PIXELS = fb_pixels(DEFAULT_WIDTH, DEFAULT_HEIGHT);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_GUARD = 3'd2,
    ST_WAIT  = 3'd3,
    ST_FLIP  = 3'd4
  } state_e;

  typedef struct packed {
    logic [19:0] addr;
    logic [31:0] data;
    logic [1:0]  mask;
  } wr_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy output; pointers carry one extra wrap bit
// so full and empty are distinguished without a separate counter.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [DW-1:0]          wr_data_i,
  input  logic                   pop_i,
  output logic [DW-1:0]          rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wptr_q;
  logic [AW:0]   rptr_q;
  logic          do_push;
  logic          do_pop;

  assign level_o   = wptr_q - rptr_q;
  assign full_o    = (level_o == (AW+1)'(DEPTH));
  assign empty_o   = (level_o == '0);
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign rd_data_o = mem_q[rptr_q[AW-1:0]];

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/display_write_queue.sv
// Buffers CPU pixel writes and drains them one RGB565 pixel at a time into the
// framebuffer write port, ordering buffer flips behind all earlier writes.
module display_write_queue
  import display_pkg::*;
#(
  parameter int          DEPTH        = 16,
  parameter int unsigned WIDTH        = DEFAULT_WIDTH,
  parameter int unsigned HEIGHT       = DEFAULT_HEIGHT,
  parameter int          GUARD_CYCLES = 2
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [19:0]            in_addr,
  input  logic [31:0]            in_data,
  input  logic [1:0]             in_mask,
  input  logic                   flip_req,
  output logic                   flip_pending,
  output logic                   flip_done,
  output logic [19:0]            display_addr,
  output logic [15:0]            display_data,
  output logic                   display_wr,
  input  logic                   display_busy,
  output logic                   display_flip_framebuffer,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            drop_count
);

  localparam logic [19:0] FB_PIX = fb_pixels(WIDTH, HEIGHT);
  localparam int          GW     = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  state_e      state_q, state_d;
  wr_entry_t   work_q, work_d;
  logic [GW-1:0] guard_q, guard_d;
  logic        flip_pending_q, flip_pending_d;
  logic [15:0] drop_q, drop_d;
  logic [19:0] hold_addr_q, hold_addr_d;
  logic [15:0] hold_data_q, hold_data_d;

  wr_entry_t   fifo_wr, fifo_rd;
  logic        push, pop, fifo_full, fifo_empty;

  logic        hi_sel;
  logic [20:0] addr_inc;
  logic [19:0] pix_addr;
  logic [15:0] pix_data;
  logic        pix_oor;
  logic        strobe;
  logic [1:0]  mask_left;

  // Readiness is forced low while reset is held so no write is taken during it.
  assign in_ready = reset_n && !fifo_full && !flip_pending_q;
  assign push     = in_valid && in_ready && (in_mask != 2'b00);
  assign fifo_wr  = '{addr: in_addr, data: in_data, mask: in_mask};

  sync_fifo #(
    .DEPTH (DEPTH),
    .DW    ($bits(wr_entry_t))
  ) u_fifo (
    .clk       (clk_sys),
    .rst_n     (reset_n),
    .push_i    (push),
    .wr_data_i (fifo_wr),
    .pop_i     (pop),
    .rd_data_o (fifo_rd),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (level)
  );

  // The high pixel sits at addr+1; a carry out of bit 19 means it wrapped and is out of frame.
  assign hi_sel    = !work_q.mask[0];
  assign addr_inc  = {1'b0, work_q.addr} + 21'd1;
  assign pix_addr  = hi_sel ? addr_inc[19:0] : work_q.addr;
  assign pix_data  = hi_sel ? work_q.data[31:16] : work_q.data[15:0];
  assign pix_oor   = (hi_sel && addr_inc[20]) || (pix_addr >= FB_PIX);
  assign strobe    = (state_q == ST_ISSUE) && !pix_oor;
  assign mask_left = hi_sel ? 2'b00 : {work_q.mask[1], 1'b0};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d        = state_q;
    work_d         = work_q;
    guard_d        = guard_q;
    drop_d         = drop_q;
    hold_addr_d    = hold_addr_q;
    hold_data_d    = hold_data_q;
    pop            = 1'b0;
    flip_pending_d = flip_pending_q;

    if (state_q == ST_FLIP)  flip_pending_d = 1'b0;
    else if (flip_req)       flip_pending_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !display_busy) begin
          pop     = 1'b1;
          work_d  = fifo_rd;
          state_d = ST_ISSUE;
        end else if (flip_pending_q && fifo_empty && !display_busy) begin
          state_d = ST_FLIP;
        end
      end
      ST_ISSUE: begin
        work_d.mask = mask_left;
        if (!pix_oor) begin
          hold_addr_d = pix_addr;
          hold_data_d = pix_data;
          guard_d     = '0;
          state_d     = ST_GUARD;
        end else begin
          if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
          state_d = (mask_left != 2'b00) ? ST_ISSUE : ST_IDLE;
        end
      end
      ST_GUARD: begin
        if (guard_q == GW'(GUARD_CYCLES - 1)) state_d = ST_WAIT;
        else                                  guard_d = guard_q + GW'(1);
      end
      ST_WAIT: begin
        if (!display_busy) state_d = (work_q.mask != 2'b00) ? ST_ISSUE : ST_IDLE;
      end
      ST_FLIP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      work_q         <= '0;
      guard_q        <= '0;
      flip_pending_q <= 1'b0;
      drop_q         <= '0;
      hold_addr_q    <= '0;
      hold_data_q    <= '0;
    end else begin
      state_q        <= state_d;
      work_q         <= work_d;
      guard_q        <= guard_d;
      flip_pending_q <= flip_pending_d;
      drop_q         <= drop_d;
      hold_addr_q    <= hold_addr_d;
      hold_data_q    <= hold_data_d;
    end
  end

  assign display_wr               = strobe;
  assign display_addr             = strobe ? pix_addr : hold_addr_q;
  assign display_data             = strobe ? pix_data : hold_data_q;
  assign display_flip_framebuffer = (state_q == ST_FLIP);
  assign flip_done                = (state_q == ST_FLIP);
  assign flip_pending             = flip_pending_q;
  assign drop_count               = drop_q;

endmodule
